// File: rtl/display_pkg.sv
// Shared display constants: board geometry, tile colour codes, update record, FSM codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    localparam int NUM_TILES  = 24;
    localparam int ADDR_W     = 5;
    localparam int TILE_W     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TILE_W-1:0] TILE_RED     = 4'd0;
    localparam logic [TILE_W-1:0] TILE_GREEN   = 4'd1;
    localparam logic [TILE_W-1:0] TILE_BLUE    = 4'd2;
    localparam logic [TILE_W-1:0] TILE_YELLOW  = 4'd3;
    localparam logic [TILE_W-1:0] TILE_CYAN    = 4'd4;
    localparam logic [TILE_W-1:0] TILE_MAGENTA = 4'd5;
    localparam logic [TILE_W-1:0] TILE_WHITE   = 4'd6;
    localparam logic [TILE_W-1:0] TILE_ORANGE  = 4'd7;
    localparam logic [TILE_W-1:0] TILE_BLACK   = 4'd8;
    localparam logic [TILE_W-1:0] TILE_PURPLE  = 4'd9;
    localparam logic [TILE_W-1:0] TILE_BROWN   = 4'd10;
    localparam logic [TILE_W-1:0] TILE_GRAY    = 4'd11;

    // Every square comes out of reset painted black.
    localparam logic [TILE_W-1:0] INIT_TILE = TILE_BLACK;

    // Commit FSM encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One queued map update.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TILE_W-1:0] tile;
    } upd_t;

    // True when a square index names a real board square.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NUM_TILES);
    endfunction

endpackage

// File: rtl/tile_map_scheduler_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Latency: 1 cycle push-to-head; head data valid whenever not empty.
// Backpressure: pushes ignored when full, pops ignored when empty; no same-cycle bypass.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Next pointer and count; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count state; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/tile_map_scheduler.sv
// Board tile map with a queued update port committed only during vertical blanking.
// Latency: read port 1 cycle; updates land one per cycle from the blanking edge onwards.
// Backpressure: req_ready drops while the 8-entry queue is full; no pop bypass.
module tile_map_scheduler
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vblank,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TILE_W-1:0] req_tile,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TILE_W-1:0] rd_tile,
    output logic [3:0]        pending,
    output logic              commit_done,
    output logic              bad_addr
);

    logic [1:0]        state_q, state_d;
    logic              vblank_q;
    logic [TILE_W-1:0] map_q [NUM_TILES];
    logic [TILE_W-1:0] rd_tile_q, rd_tile_d;
    logic              commit_done_q, commit_done_d;
    logic              bad_addr_q, bad_addr_d;
    logic              pop;
    logic              map_we;
    upd_t              push_dat;
    upd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    assign push_dat = '{addr: req_addr, tile: req_tile};

    sync_fifo #(
        .WIDTH (ADDR_W + TILE_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (req_valid),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign req_ready   = !fifo_full;
    assign pending     = 4'(fifo_cnt);
    assign rd_tile     = rd_tile_q;
    assign commit_done = commit_done_q;
    assign bad_addr    = bad_addr_q;

    // Commit FSM: wait for a blanking rising edge, drain in order, stop early if blanking ends.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        map_we        = 1'b0;
        commit_done_d = 1'b0;
        bad_addr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_vblank && !vblank_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    commit_done_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (!in_vblank) begin
                    state_d = ST_IDLE;
                end else begin
                    pop = 1'b1;
                    if (addr_in_range(head.addr)) map_we     = 1'b1;
                    else                          bad_addr_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!in_vblank) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Renderer read: sampled from the pre-commit map, zero for off-board squares.
    always_comb begin
        rd_tile_d = '0;
        if (addr_in_range(rd_addr)) rd_tile_d = map_q[rd_addr];
    end

    // Control registers: FSM state, blanking history, status pulses, read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vblank_q      <= 1'b0;
            commit_done_q <= 1'b0;
            bad_addr_q    <= 1'b0;
            rd_tile_q     <= '0;
        end else begin
            state_q       <= state_d;
            vblank_q      <= in_vblank;
            commit_done_q <= commit_done_d;
            bad_addr_q    <= bad_addr_d;
            rd_tile_q     <= rd_tile_d;
        end
    end

    // Tile map: reset paints the board, otherwise one committed update per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TILES; i++) map_q[i] <= INIT_TILE;
        end else if (map_we) begin
            map_q[head.addr] <= head.tile;
        end
    end

endmodule
